// File: rtl/b_down_timer_ctrl_pkg.sv
// Shared definitions for the down-timer controller.
// Holds the state encoding, default parameter values and a helper that sizes
// the prescaler counter.
package b_down_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PRESC = 1;

    // A prescaler of 1 still needs a one-bit counter to keep the ports legal.
    function automatic int presc_cw(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/b_down_timer_ctrl_presc.sv
// b_presc: generates a one-cycle tick every PRESC enabled cycles.
// Ports:
//   clk  - system clock, rising edge
//   re   - asynchronous active-low reset
//   en   - count enable; the counter holds when low
//   clr  - synchronous clear to zero, wins over en
//   tick - high on the enabled cycle where the counter sits at PRESC-1
module b_presc
    import b_down_timer_ctrl_pkg::*;
#(
    parameter int PRESC = DEF_PRESC
) (
    input  logic clk,
    input  logic re,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = presc_cw(PRESC);
    localparam logic [CW-1:0] LAST = CW'(PRESC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge re) begin
        if (!re) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/b_down_timer_ctrl.sv
// b_down_timer_ctrl: programmable down timer with start/stop/pause and
// auto-reload, built around a prescaled count enable.
// Ports:
//   clk, re      - system clock; asynchronous active-low reset
//   start        - pulse: load load_val and (re)start counting
//   stop         - pulse: abort to IDLE (highest priority)
//   pause        - level: hold count and prescaler while in RUN
//   auto_reload  - level: sampled at terminal count
//   load_val     - start value, zero is rejected
//   c            - current count
//   busy / done  - RUN-or-PAUSE / DONE status, decoded from next state
//   tc / err     - one-cycle terminal-count / rejected-start pulses
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | stopped, c=0, waiting for start
// ST_RUN   | counting down on each prescaler tick
// ST_PAUSE | count and prescaler frozen while pause is high
// ST_DONE  | terminal count reached without reload, c=0
module b_down_timer_ctrl
    import b_down_timer_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRESC = DEF_PRESC
) (
    input  logic             clk,
    input  logic             re,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             err
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] rel_q, rel_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             p_en, p_clr, tick;

    b_presc #(.PRESC(PRESC)) u_presc (
        .clk  (clk),
        .re   (re),
        .en   (p_en),
        .clr  (p_clr),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        rel_d   = rel_q;
        tc_d    = 1'b0;
        err_d   = 1'b0;
        p_en    = 1'b0;
        p_clr   = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            c_d     = '0;
            p_clr   = 1'b1;
        end else if (start) begin
            if (load_val != '0) begin
                state_d = ST_RUN;
                c_d     = load_val;
                rel_d   = load_val;
                p_clr   = 1'b1;
            end else begin
                // Rejected start consumes the cycle: nothing else moves.
                err_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else begin
                        p_en = 1'b1;
                        if (tick) begin
                            if (c_q > WIDTH'(1)) begin
                                c_d = c_q - WIDTH'(1);
                            end else begin
                                tc_d = 1'b1;
                                if (auto_reload) begin
                                    c_d = rel_q;
                                end else begin
                                    c_d     = '0;
                                    state_d = ST_DONE;
                                end
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge re) begin
        if (!re) begin
            state_q <= ST_IDLE;
            c_q     <= '0;
            rel_q   <= '0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            rel_q   <= rel_d;
            tc_q    <= tc_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign tc   = tc_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_b_down_timer_ctrl.sv
module tb_b_down_timer_ctrl;

    logic       clk = 1'b0;
    logic       re = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] c1, c4;
    logic       busy1, tc1, done1, err1;
    logic       busy4, tc4, done4, err4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    b_down_timer_ctrl #(.WIDTH(4), .PRESC(1)) u_p1 (
        .clk(clk), .re(re), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .load_val(load_val),
        .c(c1), .busy(busy1), .tc(tc1), .done(done1), .err(err1)
    );

    b_down_timer_ctrl #(.WIDTH(4), .PRESC(4)) u_p4 (
        .clk(clk), .re(re), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .load_val(load_val),
        .c(c4), .busy(busy4), .tc(tc4), .done(done4), .err(err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] v);
        start    = 1'b1;
        load_val = v;
        cyc();
        start    = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    initial begin
        logic [3:0] ar_c [6];
        logic       ar_t [6];
        ar_c = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
        ar_t = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        // Reset state
        #2;
        chk("rst_c", 32'(c1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_tc", 32'(tc1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_err", 32'(err1), 0);
        cyc();
        re = 1'b1;
        cyc();
        chk("idle_busy", 32'(busy1), 0);

        // One-shot count 5..0
        do_start(4'd5);
        chk("os_c5", 32'(c1), 5);
        chk("os_busy", 32'(busy1), 1);
        chk("os_tc5", 32'(tc1), 0);
        for (int i = 4; i >= 1; i--) begin
            cyc();
            chk("os_c", 32'(c1), 32'(i));
            chk("os_tc", 32'(tc1), 0);
        end
        cyc();
        chk("os_c0", 32'(c1), 0);
        chk("os_tc0", 32'(tc1), 1);
        chk("os_done", 32'(done1), 1);
        chk("os_busy0", 32'(busy1), 0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("os_hold_c", 32'(c1), 0);
            chk("os_hold_tc", 32'(tc1), 0);
            chk("os_hold_done", 32'(done1), 1);
        end

        // Auto-reload with load 3 (also restarts from DONE)
        auto_reload = 1'b1;
        do_start(4'd3);
        chk("ar_c3", 32'(c1), 3);
        chk("ar_done_clr", 32'(done1), 0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("ar_c", 32'(c1), 32'(ar_c[i]));
            chk("ar_tc", 32'(tc1), 32'(ar_t[i]));
            chk("ar_done", 32'(done1), 0);
        end
        do_stop();
        auto_reload = 1'b0;
        chk("ar_stop_c", 32'(c1), 0);

        // Pause at c=4 for three cycles
        do_start(4'd6);
        cyc();
        cyc();
        chk("pz_c4", 32'(c1), 4);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pz_hold_c", 32'(c1), 4);
            chk("pz_busy", 32'(busy1), 1);
        end
        pause = 1'b0;
        cyc();
        chk("pz_resume_c", 32'(c1), 4);
        chk("pz_resume_busy", 32'(busy1), 1);
        cyc();
        chk("pz_c3", 32'(c1), 3);
        do_stop();

        // Stop mid-run
        do_start(4'd9);
        cyc();
        cyc();
        chk("st_c7", 32'(c1), 7);
        do_stop();
        chk("st_c", 32'(c1), 0);
        chk("st_busy", 32'(busy1), 0);
        chk("st_done", 32'(done1), 0);

        // Reject zero load in IDLE
        do_start(4'd0);
        chk("rj_err", 32'(err1), 1);
        chk("rj_c", 32'(c1), 0);
        chk("rj_busy", 32'(busy1), 0);
        cyc();
        chk("rj_err_pulse", 32'(err1), 0);

        // Reject zero load while running: count does not move that edge
        do_start(4'd4);
        chk("rjr_c4", 32'(c1), 4);
        do_start(4'd0);
        chk("rjr_err", 32'(err1), 1);
        chk("rjr_c", 32'(c1), 4);
        chk("rjr_busy", 32'(busy1), 1);
        cyc();
        chk("rjr_c3", 32'(c1), 3);
        do_stop();

        // Start and stop together: stop wins
        stop = 1'b1;
        do_start(4'd5);
        stop = 1'b0;
        chk("ss_c", 32'(c1), 0);
        chk("ss_busy", 32'(busy1), 0);
        chk("ss_err", 32'(err1), 0);

        // PRESC=4 instance, load 2
        do_start(4'd2);
        chk("p4_c2_0", 32'(c4), 2);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("p4_c2", 32'(c4), 2);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("p4_c1", 32'(c4), 1);
            chk("p4_tc1", 32'(tc4), 0);
        end
        cyc();
        chk("p4_c0", 32'(c4), 0);
        chk("p4_tc", 32'(tc4), 1);
        chk("p4_done", 32'(done4), 1);

        // Retrigger while c=1 with the prescaler part-way through
        do_start(4'd2);
        for (int i = 0; i < 4; i++) cyc();
        cyc();
        cyc();
        chk("rt_c1", 32'(c4), 1);
        do_start(4'd9);
        chk("rt_c9", 32'(c4), 9);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rt_hold9", 32'(c4), 9);
        end
        cyc();
        chk("rt_c8", 32'(c4), 8);

        // Asynchronous reset between edges
        do_start(4'd9);
        cyc();
        chk("ar_pre_c", 32'(c1), 8);
        #2;
        re = 1'b0;
        #1;
        chk("arst_c1", 32'(c1), 0);
        chk("arst_busy1", 32'(busy1), 0);
        chk("arst_c4", 32'(c4), 0);
        chk("arst_busy4", 32'(busy4), 0);
        #2;
        re = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_c", 32'(c1), 0);
            chk("post_busy", 32'(busy1), 0);
            chk("post_done", 32'(done1), 0);
        end
        do_start(4'd3);
        chk("post_start", 32'(c1), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
